// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared encodings for the memory access unit
// Contents: request op encodings, FSM state enum, lane-mask constants, word-op helper.
package mem_pkg;

  typedef enum logic [1:0] {
    OP_WORD  = 2'b00,
    OP_LEFT  = 2'b01,
    OP_RIGHT = 2'b10,
    OP_RSVD  = 2'b11
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } mem_state_e;

  localparam logic [3:0]  LANE_ALL  = 4'b1111;
  localparam logic [3:0]  LANE_NONE = 4'b0000;
  localparam logic [31:0] WORD_ONES = 32'hFFFF_FFFF;

  // The reserved encoding behaves exactly like a word access.
  function automatic logic is_word_op(input mem_op_e op);
    return (op == OP_WORD) || (op == OP_RSVD);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - memory-side bus between the access unit and memory
// master: drives mem_req/mem_we/mem_addr/mem_be/mem_wdata, receives mem_rdata/mem_ack.
// slave:  the memory side of the same bundle.
interface mem_access_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_access_unit_lane_align.sv
// rtl/mem_access_unit_lane_align.sv - big-endian lane alignment and merge for word/left/right ops
// Inputs : op_i, k_i (byte offset), wdata_i, byte_en_i, mem_rdata_i, rt_old_i
// Outputs: st_wdata_o/st_be_o (store lanes), ld_data_o/ld_be_o (merged load result)
module lane_align
  import mem_pkg::*;
(
  input  mem_op_e     op_i,
  input  logic [1:0]  k_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  byte_en_i,
  input  logic [31:0] mem_rdata_i,
  input  logic [31:0] rt_old_i,
  output logic [31:0] st_wdata_o,
  output logic [3:0]  st_be_o,
  output logic [31:0] ld_data_o,
  output logic [3:0]  ld_be_o
);

  logic [1:0] k_inv;   // 3 - k for a 2-bit offset
  logic [4:0] sh_l;
  logic [4:0] sh_r;

  assign k_inv = ~k_i;
  assign sh_l  = {k_i, 3'b000};
  assign sh_r  = {k_inv, 3'b000};

  always_comb begin
    st_wdata_o = wdata_i;
    st_be_o    = byte_en_i;
    ld_data_o  = mem_rdata_i;
    ld_be_o    = LANE_ALL;
    case (op_i)
      OP_LEFT: begin
        // Memory bytes k..3 land in the register's upper bytes; low 8k bits keep rt.
        ld_data_o  = (mem_rdata_i << sh_l) | (rt_old_i & ~(WORD_ONES << sh_l));
        ld_be_o    = LANE_ALL << k_i;
        st_wdata_o = wdata_i >> sh_l;
        st_be_o    = LANE_ALL >> k_i;
      end
      OP_RIGHT: begin
        // Memory bytes 0..k land in the register's lower bytes; high bits keep rt.
        ld_data_o  = (mem_rdata_i >> sh_r) | (rt_old_i & ~(WORD_ONES >> sh_r));
        ld_be_o    = LANE_ALL >> k_inv;
        st_wdata_o = wdata_i << sh_r;
        st_be_o    = LANE_ALL << k_inv;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - IDLE/REQ/DONE load/store sequencer with left/right merge support
// Inputs : clk_i, rst_i (sync, active-high), req_valid_i, req_write_i, req_op_i, addr_i,
//          wdata_i, byte_en_i, rt_old_i
// Outputs: busy_o, done_o, addr_err_o, rdata_o, rd_byte_en_o
// Bus    : mem_if (master modport of mem_access_unit_if)
// Option : MEM_TIMEOUT_EN adds an 8-bit REQ watchdog that aborts with addr_err_o.
module mem_access_unit
  import mem_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic        req_write_i,
  input  logic [1:0]  req_op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  byte_en_i,
  input  logic [31:0] rt_old_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        addr_err_o,
  output logic [31:0] rdata_o,
  output logic [3:0]  rd_byte_en_o,
  mem_access_unit_if.master mem_if
);

  mem_state_e  state_q;
  mem_op_e     op_q;
  logic [1:0]  k_q;
  logic        write_q;
  logic [31:0] rt_old_q;
  logic        done_q;
  logic        addr_err_q;
  logic [31:0] rdata_q;
  logic [3:0]  rd_be_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [3:0]  mem_be_q;
  logic [31:0] mem_wdata_q;
`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] WD_LAST = 8'd254;   // counter value on the 255th REQ cycle
  logic [7:0]  wd_q;
`endif

  mem_op_e     op_in;
  mem_op_e     op_sel;
  logic [1:0]  k_sel;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [31:0] ld_data;
  logic [3:0]  ld_be;

  assign op_in = mem_op_e'(req_op_i);

  // In IDLE the aligner shapes the live store request; afterwards it merges
  // the returning data with the latched op/offset/rt.
  assign op_sel = (state_q == ST_IDLE) ? op_in : op_q;
  assign k_sel  = (state_q == ST_IDLE) ? addr_i[1:0] : k_q;

  lane_align u_lane_align (
    .op_i        (op_sel),
    .k_i         (k_sel),
    .wdata_i     (wdata_i),
    .byte_en_i   (byte_en_i),
    .mem_rdata_i (mem_if.mem_rdata),
    .rt_old_i    (rt_old_q),
    .st_wdata_o  (st_wdata),
    .st_be_o     (st_be),
    .ld_data_o   (ld_data),
    .ld_be_o     (ld_be)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_WORD;
      k_q         <= 2'b00;
      write_q     <= 1'b0;
      rt_old_q    <= '0;
      done_q      <= 1'b0;
      addr_err_q  <= 1'b0;
      rdata_q     <= '0;
      rd_be_q     <= LANE_NONE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= LANE_NONE;
      mem_wdata_q <= '0;
`ifdef MEM_TIMEOUT_EN
      wd_q        <= '0;
`endif
    end else begin
      done_q     <= 1'b0;
      addr_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            if (is_word_op(op_in) && (addr_i[1:0] != 2'b00)) begin
              addr_err_q <= 1'b1;
            end else begin
              state_q     <= ST_REQ;
              op_q        <= op_in;
              k_q         <= addr_i[1:0];
              write_q     <= req_write_i;
              rt_old_q    <= rt_old_i;
              mem_req_q   <= 1'b1;
              mem_we_q    <= req_write_i;
              mem_addr_q  <= {addr_i[31:2], 2'b00};
              mem_be_q    <= req_write_i ? st_be : LANE_NONE;
              mem_wdata_q <= req_write_i ? st_wdata : '0;
`ifdef MEM_TIMEOUT_EN
              wd_q        <= '0;
`endif
            end
          end
        end
        ST_REQ: begin
          if (mem_if.mem_ack) begin
            state_q     <= ST_DONE;
            done_q      <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= LANE_NONE;
            mem_wdata_q <= '0;
            if (write_q) begin
              rd_be_q <= LANE_NONE;
            end else begin
              rdata_q <= ld_data;
              rd_be_q <= ld_be;
            end
          end
`ifdef MEM_TIMEOUT_EN
          else if (wd_q == WD_LAST) begin
            state_q     <= ST_IDLE;
            addr_err_q  <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= LANE_NONE;
            mem_wdata_q <= '0;
            wd_q        <= '0;
          end else begin
            wd_q <= wd_q + 8'd1;
          end
`endif
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = done_q;
  assign addr_err_o   = addr_err_q;
  assign rdata_o      = rdata_q;
  assign rd_byte_en_o = rd_be_q;

  assign mem_if.mem_req   = mem_req_q;
  assign mem_if.mem_we    = mem_we_q;
  assign mem_if.mem_addr  = mem_addr_q;
  assign mem_if.mem_be    = mem_be_q;
  assign mem_if.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit
module tb_mem_access_unit;
  import mem_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  be;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byte_en;
  logic [31:0] rt_old;
  logic        busy_o;
  logic        done_o;
  logic        addr_err_o;
  logic [31:0] rdata_o;
  logic [3:0]  rd_byte_en_o;

  mem_access_unit_if mem_if ();

  mem_access_unit dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_write_i  (req_write),
    .req_op_i     (req_op),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .byte_en_i    (byte_en),
    .rt_old_i     (rt_old),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .addr_err_o   (addr_err_o),
    .rdata_o      (rdata_o),
    .rd_byte_en_o (rd_byte_en_o),
    .mem_if       (mem_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  exp_t sb_load[$];
  exp_t sb_store[$];

  // observations from the last access
  logic        o_req, o_we, o_stable, o_busy_ok, o_done, o_req_in_done, o_busy_after, o_done_after;
  logic [31:0] o_addr, o_wdata, o_rdata;
  logic [3:0]  o_be, o_rdbe;

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int i);
    return w[31-8*i -: 8];
  endfunction

  // Byte-by-byte reference: byte 0 is the most significant.
  function automatic exp_t model_load(input logic [1:0] op, input logic [1:0] k,
                                      input logic [31:0] m, input logic [31:0] rt);
    exp_t e;
    int kk;
    kk = int'(k);
    e = '0;
    for (int i = 0; i < 4; i++) begin
      logic take;
      logic [7:0] b;
      if (op == 2'b01) begin
        take = (i <= 3 - kk);
        b = take ? byte_of(m, i + kk) : byte_of(rt, i);
      end else if (op == 2'b10) begin
        take = (i >= 3 - kk);
        b = take ? byte_of(m, i - (3 - kk)) : byte_of(rt, i);
      end else begin
        take = 1'b1;
        b = byte_of(m, i);
      end
      e.data[31-8*i -: 8] = b;
      e.be[3-i] = take;
    end
    return e;
  endfunction

  function automatic exp_t model_store(input logic [1:0] op, input logic [1:0] k,
                                       input logic [31:0] w, input logic [3:0] ben);
    exp_t e;
    int kk;
    kk = int'(k);
    e = '0;
    if (op == 2'b00 || op == 2'b11) begin
      e.data = w;
      e.be = ben;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (op == 2'b01 && i >= kk) begin
          e.data[31-8*i -: 8] = byte_of(w, i - kk);
          e.be[3-i] = 1'b1;
        end else if (op == 2'b10 && i <= kk) begin
          e.data[31-8*i -: 8] = byte_of(w, i + (3 - kk));
          e.be[3-i] = 1'b1;
        end
      end
    end
    return e;
  endfunction

  // Drives one access; request inputs are scrambled while busy.
  task automatic run_access(input logic wr, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] ben, input logic [31:0] rt,
                            input logic [31:0] m, input int nwait, input logic noisy);
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_op = op; addr = a;
    wdata = wd; byte_en = ben; rt_old = rt;
    @(negedge clk);
    req_valid = noisy; req_write = ~wr; req_op = 2'($urandom);
    addr = $urandom; wdata = $urandom; byte_en = 4'($urandom); rt_old = $urandom;
    o_req = mem_if.mem_req; o_we = mem_if.mem_we; o_addr = mem_if.mem_addr;
    o_be = mem_if.mem_be; o_wdata = mem_if.mem_wdata;
    o_stable = 1'b1; o_busy_ok = 1'b1;
    for (int w = 0; w <= nwait; w++) begin
      if (w > 0) begin
        @(negedge clk);
        if (noisy) begin addr = $urandom; rt_old = $urandom; end
      end
      if ({mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_be, mem_if.mem_wdata}
          !== {o_req, o_we, o_addr, o_be, o_wdata}) o_stable = 1'b0;
      if (busy_o !== 1'b1 || done_o !== 1'b0) o_busy_ok = 1'b0;
      mem_if.mem_ack = (w == nwait);
      mem_if.mem_rdata = (w == nwait) ? m : $urandom;
    end
    @(negedge clk);
    mem_if.mem_ack = 1'b0; req_valid = 1'b0;
    o_done = done_o; o_rdata = rdata_o; o_rdbe = rd_byte_en_o; o_req_in_done = mem_if.mem_req;
    @(negedge clk);
    o_busy_after = busy_o; o_done_after = done_o;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_op = 2'b00; addr = '0;
    wdata = '0; byte_en = '0; rt_old = '0; mem_if.mem_ack = 1'b0; mem_if.mem_rdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy_o, done_o, addr_err_o, rdata_o, rd_byte_en_o} !== 39'd0) begin
      failures++; $display("FAIL reset_outputs got %h want 0", {busy_o, done_o, addr_err_o, rdata_o, rd_byte_en_o});
    end
    checks++;
    if ({mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_be, mem_if.mem_wdata} !== 70'd0) begin
      failures++; $display("FAIL reset_mem_bus got %h want 0", {mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_be, mem_if.mem_wdata});
    end
  endtask

  task automatic test_word_load;
    exp_t e;
    sb_load.push_back(model_load(2'b00, 2'b00, 32'hDEADBEEF, 32'h0));
    run_access(1'b0, 2'b00, 32'h100, 32'h0, 4'h0, 32'h0, 32'hDEADBEEF, 0, 1'b0);
    e = sb_load.pop_front();
    checks++;
    if ({o_req, o_we, o_addr} !== {1'b1, 1'b0, 32'h100}) begin
      failures++; $display("FAIL word_load_req got %h want %h", {o_req, o_we, o_addr}, {1'b1, 1'b0, 32'h100});
    end
    checks++;
    if (o_done !== 1'b1 || o_req_in_done !== 1'b0) begin
      failures++; $display("FAIL word_load_done_n2 got done=%b req=%b want 1 0", o_done, o_req_in_done);
    end
    checks++;
    if ({o_rdata, o_rdbe} !== {e.data, e.be}) begin
      failures++; $display("FAIL word_load_data got %h/%b want %h/%b", o_rdata, o_rdbe, e.data, e.be);
    end
    checks++;
    if (o_busy_after !== 1'b0 || o_done_after !== 1'b0) begin
      failures++; $display("FAIL word_load_idle got busy=%b done=%b want 0 0", o_busy_after, o_done_after);
    end
  endtask

  task automatic test_left_right_loads;
    exp_t e;
    for (int op = 1; op <= 2; op++) begin
      for (int k = 0; k < 4; k++) begin
        sb_load.push_back(model_load(2'(op), 2'(k), 32'h11223344, 32'hAABBCCDD));
        run_access(1'b0, 2'(op), 32'h100 + 32'(k), 32'h0, 4'h0, 32'hAABBCCDD, 32'h11223344, k, 1'b0);
        e = sb_load.pop_front();
        checks++;
        if ({o_done, o_rdata, o_rdbe} !== {1'b1, e.data, e.be}) begin
          failures++; $display("FAIL lr_load op=%0d k=%0d got %b/%h/%b want 1/%h/%b", op, k, o_done, o_rdata, o_rdbe, e.data, e.be);
        end
        checks++;
        if (o_addr !== 32'h100 || o_stable !== 1'b1 || o_busy_ok !== 1'b1) begin
          failures++; $display("FAIL lr_load_bus op=%0d k=%0d got addr=%h stable=%b busy=%b want 100 1 1", op, k, o_addr, o_stable, o_busy_ok);
        end
      end
    end
  endtask

  task automatic test_stores;
    exp_t e;
    logic [31:0] rd_before;
    logic [31:0] w;
    logic [3:0] ben;
    for (int op = 0; op <= 2; op++) begin
      for (int k = 0; k < 4; k++) begin
        if (op == 0 && k != 0) continue;
        w = (op == 2 && k == 2) ? 32'h11223344 : $urandom;
        ben = 4'($urandom);
        sb_store.push_back(model_store(2'(op), 2'(k), w, ben));
        rd_before = rdata_o;
        run_access(1'b1, 2'(op), 32'h100 + 32'(k), w, ben, 32'h0, 32'h0, 1, 1'b1);
        e = sb_store.pop_front();
        checks++;
        if ({o_req, o_we, o_addr, o_wdata, o_be} !== {1'b1, 1'b1, 32'h100, e.data, e.be}) begin
          failures++; $display("FAIL store_bus op=%0d k=%0d got %b%b %h %h %b want 11 100 %h %b", op, k, o_req, o_we, o_addr, o_wdata, o_be, e.data, e.be);
        end
        checks++;
        if ({o_done, o_rdbe, o_rdata} !== {1'b1, 4'b0000, rd_before} || o_stable !== 1'b1) begin
          failures++; $display("FAIL store_done op=%0d k=%0d got %b/%b/%h stable=%b want 1/0000/%h", op, k, o_done, o_rdbe, o_rdata, o_stable, rd_before);
        end
      end
    end
  endtask

  task automatic test_addr_err;
    logic [1:0] ops [4] = '{2'b00, 2'b00, 2'b00, 2'b11};
    logic [1:0] offs [4] = '{2'd3, 2'd1, 2'd2, 2'd1};
    logic seen_req;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_op = ops[t]; addr = 32'h100 + 32'(offs[t]);
      @(negedge clk);
      req_valid = 1'b0;
      seen_req = mem_if.mem_req;
      checks++;
      if ({addr_err_o, busy_o, done_o} !== 3'b100) begin
        failures++; $display("FAIL addr_err_pulse t=%0d got err/busy/done=%b want 100", t, {addr_err_o, busy_o, done_o});
      end
      @(negedge clk);
      seen_req = seen_req | mem_if.mem_req;
      checks++;
      if ({addr_err_o, busy_o, seen_req} !== 3'b000) begin
        failures++; $display("FAIL addr_err_after t=%0d got err/busy/req=%b want 000", t, {addr_err_o, busy_o, seen_req});
      end
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    logic [1:0] op;
    logic [1:0] k;
    logic [31:0] m;
    logic [31:0] rt;
    for (int n = 0; n < 8; n++) begin
      op = 2'($urandom);
      k = (op == 2'b00 || op == 2'b11) ? 2'd0 : 2'($urandom);
      m = $urandom; rt = $urandom;
      sb_load.push_back(model_load(op, k, m, rt));
      run_access(1'b0, op, {20'h0, 10'(n), k} + 32'h400, 32'h0, 4'h0, rt, m, n % 3, 1'b1);
      e = sb_load.pop_front();
      checks++;
      if ({o_done, o_rdata, o_rdbe} !== {1'b1, e.data, e.be} || o_stable !== 1'b1 || o_busy_ok !== 1'b1) begin
        failures++; $display("FAIL b2b n=%0d got %b/%h/%b stable=%b busy=%b want 1/%h/%b", n, o_done, o_rdata, o_rdbe, o_stable, o_busy_ok, e.data, e.be);
      end
    end
  endtask

  task automatic test_reset_during_req;
    logic seen_done;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_op = 2'b00; addr = 32'h200;
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (mem_if.mem_req !== 1'b1) begin
      failures++; $display("FAIL rst_req_started got %b want 1", mem_if.mem_req);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({mem_if.mem_req, busy_o, rdata_o, rd_byte_en_o} !== 38'd0) begin
      failures++; $display("FAIL rst_req_drop got req=%b busy=%b rdata=%h be=%b want all 0", mem_if.mem_req, busy_o, rdata_o, rd_byte_en_o);
    end
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'hCAFEF00D;
    seen_done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      mem_if.mem_ack = 1'b0;
      seen_done = seen_done | done_o | busy_o;
    end
    checks++;
    if (seen_done !== 1'b0 || rdata_o !== 32'h0) begin
      failures++; $display("FAIL rst_late_ack got activity=%b rdata=%h want 0 0", seen_done, rdata_o);
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout;
    int cnt;
    logic seen_err, seen_done;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_op = 2'b00; addr = 32'h300;
    @(negedge clk);
    req_valid = 1'b0;
    cnt = 0; seen_err = 1'b0; seen_done = 1'b0;
    while (busy_o && cnt < 400) begin
      cnt++;
      @(negedge clk);
      seen_err = seen_err | addr_err_o;
      seen_done = seen_done | done_o;
    end
    checks++;
    if (cnt !== 255 || seen_err !== 1'b1 || seen_done !== 1'b0 || busy_o !== 1'b0) begin
      failures++; $display("FAIL timeout got cycles=%0d err=%b done=%b busy=%b want 255 1 0 0", cnt, seen_err, seen_done, busy_o);
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_word_load();
    test_left_right_loads();
    test_stores();
    test_addr_err();
    test_back_to_back();
    test_reset_during_req();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Clk  in  1  sole clock; all state updates on rising edge.
REQ-002 Reset  in  1  synchronous, active-high reset.
REQ-003 Req_valid  in  1  controller access request, sampled only in IDLE.
REQ-004 Req_write  in  1  1 = store, 0 = load.
REQ-005 Req_op  in  2  00 word, 01 left (lwl/swl), 10 right (lwr/swr), 11 reserved (treated as word).
REQ-006 Addr  in  32  byte address.
REQ-007 Wdata  in  32  store data (rt).
REQ-008 Byte_en  in  4  store lane enables for word op (Mem_byte_write).
REQ-009 Rt_old  in  32  current rt, merged on left/right loads.
REQ-010 Busy  out  1  high whenever state != IDLE; stalls controller.
REQ-011 Done  out  1  one-cycle completion pulse.
REQ-012 Addr_err  out  1  one-cycle pulse: word op with Addr[1:0] != 0.
REQ-013 Rdata  out  32  aligned/merged load result, held until next Done.
REQ-014 Rd_byte_en  out  4  register byte write enables for the load result.
REQ-015 Mem_req, Mem_we  out  1 each  memory request / write strobe.
REQ-016 Mem_addr  out  32  {Addr[31:2],2'b00}.
REQ-017 Mem_be  out  4;  Mem_wdata  out  32  store lanes/data.
REQ-018 Mem_rdata  in  32;  Mem_ack  in  1  memory read data and acknowledge.

Function
REQ-019 Byte order SHALL be big-endian: byte offset 0 = bits 31:24; k = Addr[1:0].
REQ-020 FSM states SHALL be IDLE, REQ, DONE; IDLE->REQ on Req_valid (legal), REQ->DONE on Mem_ack, DONE->IDLE unconditionally.
REQ-021 In IDLE with Req_valid and illegal alignment: Addr_err pulses next cycle, no Mem_req, state stays IDLE.
REQ-022 All request inputs SHALL be latched on IDLE acceptance; changes during Busy ignored; Req_valid during Busy ignored.
REQ-023 Mem_req, Mem_we, Mem_addr, Mem_be, Mem_wdata SHALL be registered, stable throughout REQ, and 0 outside REQ.
REQ-024 Minimum latency: Req_valid cycle N, Mem_req cycle N+1, ack at N+1 -> Done cycle N+2; each extra wait cycle adds one.
REQ-025 Mem_rdata SHALL be captured on the cycle Mem_ack is high in REQ; Mem_ack in IDLE/DONE ignored.
REQ-026 Word: Rdata = Mem_rdata, Rd_byte_en 1111; store Mem_be = Byte_en, Mem_wdata = Wdata.
REQ-027 LWL: Rdata = (Mem_rdata << 8k) merged with Rt_old low 8k bits; Rd_byte_en k0..3 = 1111,1110,1100,1000.
REQ-028 LWR: Rdata = (Mem_rdata >> 8(3-k)) merged with Rt_old high bits; Rd_byte_en k0..3 = 0001,0011,0111,1111.
REQ-029 SWL: Mem_wdata = Wdata >> 8k, Mem_be k0..3 = 1111,0111,0011,0001.
REQ-030 SWR: Mem_wdata = Wdata << 8(3-k), Mem_be k0..3 = 1000,1100,1110,1111.
REQ-031 Stores SHALL drive Rd_byte_en = 0000 at Done; Rdata unchanged.

Reset
REQ-032 Reset SHALL force IDLE and zero every output, Rdata included, on the next edge.
REQ-033 Reset during REQ SHALL drop Mem_req the next cycle with no Done; a late Mem_ack is ignored.

Configuration
REQ-034 With MEM_TIMEOUT_EN defined: 8-bit watchdog counts REQ cycles; at 255 without ack, abort to IDLE, pulse Addr_err, no Done.
REQ-035 Without MEM_TIMEOUT_EN: REQ waits indefinitely; no counter logic.

Structure
REQ-036 Shared package mem_pkg SHALL hold Req_op encodings, FSM state enum and lane-mask constants.
REQ-037 Alignment/merge logic SHALL be one combinational sub-module lane_align; FSM and registers stay in mem_access_unit.

Verification
REQ-038 Word load Addr=0x100, Mem_rdata=0xDEADBEEF, ack next cycle -> Done at N+2, Rdata=0xDEADBEEF, Rd_byte_en=1111.
REQ-039 LWL Addr=0x101, Mem_rdata=0x11223344, Rt_old=0xAABBCCDD -> Rdata=0x223344DD, Rd_byte_en=1110.
REQ-040 SWR Addr=0x102, Wdata=0x11223344 -> Mem_addr=0x100, Mem_wdata=0x22334400, Mem_be=1110, Mem_we=1.
REQ-041 Word load Addr=0x103 -> Addr_err pulse, Mem_req never asserted, Busy stays 0.
REQ-042 Ack withheld 5 cycles, Reset at cycle 3 -> Mem_req drops next cycle, no Done, late ack ignored.
REQ-043 MEM_TIMEOUT_EN, no ack -> abort after 255 REQ cycles, Addr_err pulse, Busy 0.
